// File: rtl/param_burst_memory.sv
// rtl/param_burst_memory.sv - fixed-latency burst main-memory model serving whole lines as BURST_LEN beats
// Open-page (short latency) hits are tracked only when PARAM_MEM_PAGE_EN is defined.
module param_burst_memory #(
    parameter int DELAY      = 50,
    parameter int PAGE_DELAY = 25,
    parameter int BURST_LEN  = 4,
    parameter int LINE_WIDTH = 256,
    parameter int PAGE_BYTES = 512,
    parameter int MEM_LINES  = 4096
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            read,
    input  logic                            write,
    input  logic [31:0]                     address,
    input  logic [LINE_WIDTH/BURST_LEN-1:0] burst_i,
    output logic [LINE_WIDTH/BURST_LEN-1:0] burst_o,
    output logic                            resp
);
    localparam int BW     = LINE_WIDTH / BURST_LEN;
    localparam int OFF_W  = $clog2(LINE_WIDTH / 8);
    localparam int IDX_W  = $clog2(MEM_LINES);
    localparam int MAX_D  = (DELAY > PAGE_DELAY) ? DELAY : PAGE_DELAY;
    localparam int CNT_W  = $clog2(MAX_D + 1);
    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

    state_t                 state, state_n;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       req_delay;
    logic [BEAT_W-1:0]      beat;
    logic [BEAT_W-1:0]      rd_beat;
    logic [IDX_W-1:0]       idx;
    logic                   op_read;
    logic [LINE_WIDTH-1:0]  mem [MEM_LINES];
    logic [BW-1:0]          stage [BURST_LEN];
    logic [LINE_WIDTH-1:0]  rd_line;
    logic [LINE_WIDTH-1:0]  wr_line;
    logic [BW-1:0]          rd_data;
    logic                   unused_addr_bits;

    // Offset bits and aliased upper line-index bits never select storage
    assign unused_addr_bits = ^{address[OFF_W-1:0], address[31:OFF_W+IDX_W]};

`ifdef PARAM_MEM_PAGE_EN
    localparam int PAGE_W = $clog2(PAGE_BYTES);
    logic                page_valid;
    logic [31-PAGE_W:0]  open_page;

    assign req_delay = (page_valid && open_page == address[31:PAGE_W]) ?
                       CNT_W'(PAGE_DELAY) : CNT_W'(DELAY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            page_valid <= 1'b0;
            open_page  <= '0;
        end else if (state == IDLE && (read || write)) begin
            page_valid <= 1'b1;
            open_page  <= address[31:PAGE_W];
        end
    end
`else
    assign req_delay = CNT_W'(DELAY);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (read || write)      state_n = WAIT;
            WAIT:    if (cnt == CNT_W'(1))   state_n = BURST;
            BURST:   if (beat == LAST_BEAT)  state_n = IDLE;
            default:                         state_n = IDLE;
        endcase
    end

    // Beat presented after the coming edge: 0 on WAIT->BURST, otherwise the next one
    assign rd_beat = (state == BURST) ? beat + BEAT_W'(1) : '0;
    assign rd_line = mem[idx];
    assign rd_data = rd_line[int'(rd_beat) * BW +: BW];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            beat    <= '0;
            idx     <= '0;
            op_read <= 1'b0;
            resp    <= 1'b0;
            burst_o <= '0;
        end else begin
            case (state)
                IDLE: if (read || write) begin
                    idx     <= address[OFF_W +: IDX_W];
                    op_read <= read;
                    cnt     <= req_delay;
                end
                WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (state_n == BURST) begin
                        resp    <= 1'b1;
                        beat    <= '0;
                        burst_o <= op_read ? rd_data : '0;
                    end
                end
                BURST: begin
                    if (beat == LAST_BEAT) begin
                        resp    <= 1'b0;
                        beat    <= '0;
                        burst_o <= '0;
                    end else begin
                        beat    <= rd_beat;
                        burst_o <= op_read ? rd_data : '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Last beat bypasses staging so the full line commits on the edge ending it
    always_comb begin
        wr_line = '0;
        for (int k = 0; k < BURST_LEN; k++)
            wr_line[k*BW +: BW] = (k == BURST_LEN - 1) ? burst_i : stage[k];
    end

    // Storage and staging are deliberately unreset; reset forces IDLE so nothing commits
    always_ff @(posedge clk) begin
        if (state == BURST && !op_read) begin
            stage[beat] <= burst_i;
            if (beat == LAST_BEAT) mem[idx] <= wr_line;
        end
    end
endmodule

// File: tb/tb_param_burst_memory.sv
// tb/tb_param_burst_memory.sv - randomized bench for param_burst_memory against a line/latency model
`timescale 1ns/1ps
module tb_param_burst_memory;
    localparam int DELAY = 50, PAGE_DELAY = 25, BL = 4, LW = 256, BW = 64;
    localparam int PAGE_BYTES = 512, MEM_LINES = 4096;
`ifdef PARAM_MEM_PAGE_EN
    localparam int HIT_LAT = 25;
`else
    localparam int HIT_LAT = 50;
`endif

    logic          clk = 1'b0, rst = 1'b1, read = 1'b0, write = 1'b0;
    logic [31:0]   address = '0;
    logic [BW-1:0] burst_i = '0;
    logic [BW-1:0] burst_o;
    logic          resp;

    param_burst_memory #(
        .DELAY(DELAY), .PAGE_DELAY(PAGE_DELAY), .BURST_LEN(BL),
        .LINE_WIDTH(LW), .PAGE_BYTES(PAGE_BYTES), .MEM_LINES(MEM_LINES)
    ) dut (
        .clk(clk), .rst(rst), .read(read), .write(write), .address(address),
        .burst_i(burst_i), .burst_o(burst_o), .resp(resp)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model: expected line per line index, open page, and the transaction in flight
    logic [LW-1:0] mm [int];
    bit            pv = 1'b0;
    int            open_pg = 0;
    bit            m_act = 1'b0, m_rd = 1'b0;
    int            m_lat = 0, acc_edge = 0;
    logic [LW-1:0] m_line = '0;

    int            obs_lat = -1, nb = 0;
    logic [BW-1:0] obs_beat [BL];
    int            n_chk = 0, n_fail = 0;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, got, want);
        end
    endtask

    int            ck;
    logic          er;
    logic [BW-1:0] eb;
    always @(negedge clk) begin
        ck = cyc - acc_edge;
        er = m_act && ck >= m_lat && ck < m_lat + BL;
        eb = '0;
        if (er && m_rd) eb = m_line[(ck - m_lat) * BW +: BW];
        check("resp", {63'd0, resp}, {63'd0, er});
        check("burst_o", burst_o, eb);
        if (resp && nb < BL) begin
            if (nb == 0) obs_lat = ck;
            obs_beat[nb] = burst_o;
            nb++;
        end
    end

    // Drives one transaction on the model's own timeline; rst_beat >= 0 resets during that beat
    task automatic txn(input bit rd, input bit wr, input logic [31:0] a,
                       input logic [LW-1:0] line, input int rst_beat);
        int idx, pg, lat;
        idx = int'(a[16:5]);
        pg  = int'(a[31:9]);
        lat = DELAY;
`ifdef PARAM_MEM_PAGE_EN
        if (pv && open_pg == pg) lat = PAGE_DELAY;
        pv = 1'b1;
        open_pg = pg;
`endif
        m_lat = lat; m_rd = rd; m_line = rd ? mm[idx] : line;
        acc_edge = cyc + 1; m_act = 1'b1; nb = 0; obs_lat = -1;
        read = rd; write = wr; address = a;
        @(posedge clk); #1;
        address = $urandom;
        burst_i = {$urandom, $urandom};
        repeat (lat) @(posedge clk);
        #1;
        for (int j = 0; j < BL; j++) begin
            if (j > 0) begin @(posedge clk); #1; end
            if (j == rst_beat) begin
                rst = 1'b1; m_act = 1'b0; pv = 1'b0; read = 1'b0; write = 1'b0;
                @(posedge clk); #1;
                rst = 1'b0;
                return;
            end
            burst_i = line[j*BW +: BW];
        end
        @(posedge clk); #1;
        if (!rd) mm[idx] = line;
        read = 1'b0; write = 1'b0; m_act = 1'b0;
        burst_i = {$urandom, $urandom};
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] l;
        for (int i = 0; i < LW / 32; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    initial begin
        logic [LW-1:0] l40, l20, l1000;
        logic [31:0]   a;
        bit            rd, wr;
        int            rb;
        l40   = {64'h0000_0040_0000_0003, 64'h0000_0040_0000_0002,
                 64'h0000_0040_0000_0001, 64'h0000_0040_0000_0000};
        l20   = {64'h2020_2020_0000_0003, 64'h2020_2020_0000_0002,
                 64'h2020_2020_0000_0001, 64'h2020_2020_0000_0000};
        l1000 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        txn(0, 1, 32'h40,   l40, -1);
        txn(0, 1, 32'h20,   l20, -1);
        txn(0, 1, 32'h80,   rand_line(), -1);
        txn(0, 1, 32'h200,  rand_line(), -1);
        txn(0, 1, 32'h1200, rand_line(), -1);

        // Contents must survive reset; the open page must not
        rst = 1'b1; pv = 1'b0;
        @(posedge clk); #1 rst = 1'b0;

        txn(1, 0, 32'h40, '0, -1);
        check("lat_0x40", 64'(obs_lat), 64'd50);
        check("beat0_0x40", obs_beat[0], 64'h0000_0040_0000_0000);
        check("beat3_0x40", obs_beat[3], 64'h0000_0040_0000_0003);

        txn(0, 1, 32'h1000, l1000, -1);
        txn(1, 0, 32'h1000, '0, -1);
        check("lat_0x1000_hit", 64'(obs_lat), 64'(HIT_LAT));
        check("beat1_0x1000", obs_beat[1], 64'h2222_2222_2222_2222);
        txn(1, 0, 32'h1200, '0, -1);
        check("lat_0x1200_miss", 64'(obs_lat), 64'd50);

        txn(1, 1, 32'h80, rand_line(), -1);
        txn(1, 0, 32'h80, '0, -1);

        txn(0, 1, 32'h200, rand_line(), 2);
        txn(1, 0, 32'h200, '0, -1);
        check("lat_after_rst", 64'(obs_lat), 64'd50);

        txn(1, 0, 32'h3F, '0, -1);
        check("beat2_0x3f", obs_beat[2], 64'h2020_2020_0000_0002);
        txn(1, 0, 32'h20 + MEM_LINES * 32, '0, -1);
        check("beat0_alias", obs_beat[0], 64'h2020_2020_0000_0000);

        txn(1, 0, 32'h1000, '0, -1);
        check("lat_b2b_first", 64'(obs_lat), 64'd50);
        txn(1, 0, 32'h1008, '0, -1);
        check("lat_b2b_second", 64'(obs_lat), 64'(HIT_LAT));

        for (int i = 0; i < 40; i++) begin
            a = $urandom & 32'h0000_1FFF;
            if ($urandom_range(0, 3) == 0) a[31:17] = 15'($urandom);
            rd = 1'($urandom_range(0, 1));
            wr = !rd || ($urandom_range(0, 4) == 0);
            if (rd && !mm.exists(int'(a[16:5]))) begin rd = 1'b0; wr = 1'b1; end
            rb = (!rd && $urandom_range(0, 9) == 0) ? int'($urandom_range(0, BL - 1)) : -1;
            txn(rd, wr, a, rand_line(), rb);
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end

        repeat (2) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
